// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The master side drives stage status; the slave side returns stall/bubble/flush controls.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       rs1_l1;
  logic [4:0]       rs2_l1;
  logic             use_rs1_l1;
  logic             use_rs2_l1;
  logic [4:0]       rd_l2;
  logic             is_load_l2;
  logic             redirect_l2;
  logic             mdu_req_l2;
  logic             mdu_done;
  logic             mem_req_l3;
  logic             dmem_ready;
  logic             cnt_clr;
  logic             stall_l0;
  logic             stall_l1;
  logic             stall_l2;
  logic             stall_l3;
  logic             bubble_l2;
  logic             bubble_l3;
  logic             flush_l1;
  logic             mdu_start;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_l1, rs2_l1, use_rs1_l1, use_rs2_l1, rd_l2, is_load_l2,
           redirect_l2, mdu_req_l2, mdu_done, mem_req_l3, dmem_ready, cnt_clr,
    input  stall_l0, stall_l1, stall_l2, stall_l3, bubble_l2, bubble_l3,
           flush_l1, mdu_start, busy, stall_cnt
  );

  modport slave (
    input  rs1_l1, rs2_l1, use_rs1_l1, use_rs2_l1, rd_l2, is_load_l2,
           redirect_l2, mdu_req_l2, mdu_done, mem_req_l3, dmem_ready, cnt_clr,
    output stall_l0, stall_l1, stall_l2, stall_l3, bubble_l2, bubble_l3,
           flush_l1, mdu_start, busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 4-stage core: load-use, MDU sequencing,
// dmem wait freeze and l2 redirect, plus a saturating stall-cycle counter.
//
// state    | meaning
// RUN      | normal issue; hazards resolved combinationally
// MDU_BUSY | MDU launched, holding l0..l2 until mdu_done
// MDU_HOLD | MDU result ready but pipeline frozen by dmem wait
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {RUN, MDU_BUSY, MDU_HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic freeze;
  logic load_use;

  assign freeze   = hz.mem_req_l3 & ~hz.dmem_ready;
  assign load_use = hz.is_load_l2 & (hz.rd_l2 != 5'd0) &
                    ((hz.use_rs1_l1 & (hz.rs1_l1 == hz.rd_l2)) |
                     (hz.use_rs2_l1 & (hz.rs2_l1 == hz.rd_l2)));

  logic s0, s1, s2, s3, b2, b3, f1, start;

  always_comb begin
    s0      = 1'b0;
    s1      = 1'b0;
    s2      = 1'b0;
    s3      = 1'b0;
    b2      = 1'b0;
    b3      = 1'b0;
    f1      = 1'b0;
    start   = 1'b0;
    state_d = state_q;
    if (freeze) begin
      s0 = 1'b1;
      s1 = 1'b1;
      s2 = 1'b1;
      s3 = 1'b1;
      if (state_q == MDU_BUSY && hz.mdu_done) state_d = MDU_HOLD;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.mdu_req_l2) begin
            start   = 1'b1;
            s0      = 1'b1;
            s1      = 1'b1;
            s2      = 1'b1;
            b3      = 1'b1;
            state_d = MDU_BUSY;
          end else if (hz.redirect_l2) begin
            // l1 is killed, so any load-use against it is moot
            f1 = 1'b1;
          end else if (load_use) begin
            s0 = 1'b1;
            s1 = 1'b1;
            b2 = 1'b1;
          end
        end
        MDU_BUSY: begin
          if (hz.mdu_done) begin
            state_d = RUN;
          end else begin
            s0 = 1'b1;
            s1 = 1'b1;
            s2 = 1'b1;
            b3 = 1'b1;
          end
        end
        MDU_HOLD: state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  // Outputs are gated so they read zero for the whole time reset is held
  assign hz.stall_l0  = s0 & rst_n;
  assign hz.stall_l1  = s1 & rst_n;
  assign hz.stall_l2  = s2 & rst_n;
  assign hz.stall_l3  = s3 & rst_n;
  assign hz.bubble_l2 = b2 & rst_n;
  assign hz.bubble_l3 = b3 & rst_n;
  assign hz.flush_l1  = f1 & rst_n;
  assign hz.mdu_start = start & rst_n;
  assign hz.busy      = (state_q != RUN) & rst_n;
  assign hz.stall_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (hz.cnt_clr)
      cnt_d = '0;
    else if (s0 && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl, checked every cycle against
// a behavioural model of the pipeline hazard rules.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // model: 0 = idle, 1 = waiting for MDU result, 2 = result held under freeze
  int   m_mdu = 0;
  int   m_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
  hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  function automatic logic [8:0] act_vec();
    return {hz.stall_l0, hz.stall_l1, hz.stall_l2, hz.stall_l3, hz.bubble_l2,
            hz.bubble_l3, hz.flush_l1, hz.mdu_start, hz.busy};
  endfunction

  task automatic chk_vec(string tag, logic [8:0] exp);
    checks++;
    assert (act_vec() === exp) else begin
      failures++;
      $error("FAIL %s ctrl got=%b want=%b", tag, act_vec(), exp);
    end
  endtask

  task automatic chk_cnt(string tag, int exp);
    checks++;
    assert (hz.stall_cnt === CNT_W'(exp)) else begin
      failures++;
      $error("FAIL %s stall_cnt got=%0d want=%0d", tag, hz.stall_cnt, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rs1_l1 = 0; hz.rs2_l1 = 0; hz.use_rs1_l1 = 0; hz.use_rs2_l1 = 0;
    hz.rd_l2 = 0; hz.is_load_l2 = 0; hz.redirect_l2 = 0; hz.mdu_req_l2 = 0;
    hz.mdu_done = 0; hz.mem_req_l3 = 0; hz.dmem_ready = 0; hz.cnt_clr = 0;
  endtask

  // One cycle: compare at negedge against the model, then advance the model at posedge.
  task automatic step(string tag);
    bit frozen, hit, st0, st1, st2, st3, bb2, bb3, fl, go;
    @(negedge clk);
    assert (!(hz.redirect_l2 && hz.mdu_req_l2)) else $error("illegal redirect with mdu_req");
    frozen = hz.mem_req_l3 && !hz.dmem_ready;
    hit = hz.is_load_l2 && hz.rd_l2 != 0 &&
          ((hz.use_rs1_l1 && hz.rs1_l1 == hz.rd_l2) || (hz.use_rs2_l1 && hz.rs2_l1 == hz.rd_l2));
    {st0, st1, st2, st3, bb2, bb3, fl, go} = '0;
    if (frozen) {st0, st1, st2, st3} = 4'hF;
    else if (m_mdu == 1 && !hz.mdu_done) {st0, st1, st2, bb3} = 4'hF;
    else if (m_mdu == 0 && hz.mdu_req_l2) {go, st0, st1, st2, bb3} = 5'h1F;
    else if (m_mdu == 0 && hz.redirect_l2) fl = 1;
    else if (m_mdu == 0 && hit) {st0, st1, bb2} = 3'h7;
    chk_vec(tag, {st0, st1, st2, st3, bb2, bb3, fl, go, 1'(m_mdu != 0)});
    chk_cnt(tag, m_cnt);
    @(posedge clk);
    if (hz.cnt_clr) m_cnt = 0;
    else if (st0) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    if (frozen) begin
      if (m_mdu == 1 && hz.mdu_done) m_mdu = 2;
    end else if (m_mdu == 0 && hz.mdu_req_l2) m_mdu = 1;
    else if ((m_mdu == 1 && hz.mdu_done) || m_mdu == 2) m_mdu = 0;
    #1;
  endtask

  initial begin
    clear_inputs();
    hz.mem_req_l3 = 1; hz.mdu_req_l2 = 1;
    #12;
    chk_vec("reset_outputs", 9'b0);
    chk_cnt("reset_cnt", 0);
    clear_inputs();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // load-use: load x5 in l2, add x6,x5,x1 in l1
    hz.is_load_l2 = 1; hz.rd_l2 = 5; hz.use_rs1_l1 = 1; hz.rs1_l1 = 5; hz.rs2_l1 = 1;
    step("lu_stall");
    hz.is_load_l2 = 0;
    step("lu_release");
    chk_cnt("lu_cnt", 1);
    hz.is_load_l2 = 1; hz.rd_l2 = 0; hz.rs1_l1 = 0;
    step("lu_x0");
    clear_inputs();

    // MDU: done on cycle 7
    hz.mdu_req_l2 = 1;
    step("mdu_start");
    for (int i = 1; i < 7; i++) step("mdu_wait");
    hz.mdu_done = 1;
    step("mdu_done");
    hz.mdu_req_l2 = 0; hz.mdu_done = 0;
    step("mdu_after");
    chk_cnt("mdu_cnt", 8);

    // MDU done while frozen by dmem wait
    hz.cnt_clr = 1;
    step("clr");
    hz.cnt_clr = 0; hz.mdu_req_l2 = 1;
    step("mf_start");
    step("mf_wait");
    hz.mem_req_l3 = 1; hz.mdu_done = 1;
    step("mf_done_frozen");
    hz.mdu_done = 0;
    step("mf_hold");
    hz.dmem_ready = 1;
    step("mf_release");
    clear_inputs();
    step("mf_run");

    // redirect beats load-use
    hz.redirect_l2 = 1; hz.is_load_l2 = 1; hz.rd_l2 = 7; hz.use_rs2_l1 = 1; hz.rs2_l1 = 7;
    step("redir_lu");
    clear_inputs();

    // redirect deferred through a 3-cycle freeze
    hz.redirect_l2 = 1; hz.mem_req_l3 = 1;
    for (int i = 0; i < 3; i++) step("redir_frozen");
    hz.dmem_ready = 1;
    step("redir_release");
    clear_inputs();

    // saturation and clear
    hz.mem_req_l3 = 1;
    for (int i = 0; i < 20; i++) step("sat");
    chk_cnt("sat_value", CMAX);
    hz.cnt_clr = 1;
    step("sat_clr");
    hz.cnt_clr = 0; hz.mem_req_l3 = 0;
    step("sat_after_clr");
    chk_cnt("clr_value", 0);

    // reset while in MDU_BUSY
    hz.mdu_req_l2 = 1;
    step("rst_mdu_start");
    step("rst_mdu_wait");
    rst_n = 0; #1;
    chk_vec("rst_mid_mdu", 9'b0);
    chk_cnt("rst_mid_cnt", 0);
    m_mdu = 0; m_cnt = 0;
    hz.mdu_req_l2 = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    step("rst_after");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      hz.rs1_l1     = 5'($urandom_range(0, 3));
      hz.rs2_l1     = 5'($urandom_range(0, 3));
      hz.rd_l2      = 5'($urandom_range(0, 3));
      hz.use_rs1_l1 = 1'($urandom);
      hz.use_rs2_l1 = 1'($urandom);
      hz.is_load_l2 = 1'($urandom);
      hz.mdu_req_l2 = ($urandom_range(0, 99) < 15);
      hz.redirect_l2 = !hz.mdu_req_l2 && ($urandom_range(0, 99) < 15);
      hz.mdu_done   = (m_mdu == 1) && ($urandom_range(0, 99) < 30);
      hz.mem_req_l3 = ($urandom_range(0, 99) < 30);
      hz.dmem_ready = 1'($urandom);
      hz.cnt_clr    = ($urandom_range(0, 99) < 3);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
